// File: rtl/tick_burst_sequencer_if.sv
// ---------------------------------------------------------------------------
// tick_burst_sequencer_if
// Configuration channel for the tick burst sequencer. A burst is described by
// a period modulus and a tick count and is handed over with a valid/ready
// handshake.
//
// Signals
//   cfg_valid   master -> slave  configuration offered
//   cfg_ready   slave -> master  configuration can be accepted this cycle
//   cfg_period  master -> slave  period modulus, counter runs 0..cfg_period
//   cfg_count   master -> slave  ticks in the burst, 0 means an empty burst
// ---------------------------------------------------------------------------
interface tick_burst_sequencer_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
);
   logic             cfg_valid;
   logic             cfg_ready;
   logic [WIDTH-1:0] cfg_period;
   logic [CNT_W-1:0] cfg_count;

   modport master (
      output cfg_valid,
      output cfg_period,
      output cfg_count,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid,
      input  cfg_period,
      input  cfg_count,
      output cfg_ready
   );
endinterface

// File: rtl/tick_burst_sequencer.sv
// ---------------------------------------------------------------------------
// tick_burst_sequencer
// Emits a burst of evenly spaced one-cycle tick strobes. A programmable-modulus
// period counter sets the spacing (period+1 cycles) and a tick index counts the
// strobes of the burst. Used to pace sample/symbol strobes into the TX datapath.
//
// Ports
//   clk         in   1      clock
//   rst         in   1      synchronous reset, active-high
//   cfg         slave       configuration channel (valid/ready, period, count)
//   i_abort     in   1      stop the current burst, no done pulse
//   o_tick      out  1      registered one-cycle tick strobe
//   o_tick_idx  out  CNT_W  index of the current tick, valid while o_tick=1
//   o_busy      out  1      burst in progress
//   o_done      out  1      one-cycle pulse after the last tick of a burst
//
// Build option
//   TICK_SEQ_PENDING_EN  when defined, a one-deep shadow register accepts the
//                        next configuration while a burst runs and chains it
//                        directly after the last tick.
// ---------------------------------------------------------------------------
module tick_burst_sequencer #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   tick_burst_sequencer_if.slave  cfg,
   input  logic                   i_abort,
   output logic                   o_tick,
   output logic [CNT_W-1:0]       o_tick_idx,
   output logic                   o_busy,
   output logic                   o_done
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           r_state, w_stateNext;
   logic [WIDTH-1:0] r_cnt, w_cntNext;
   logic [WIDTH-1:0] r_period, w_periodNext;
   logic [CNT_W-1:0] r_count, w_countNext;
   logic [CNT_W-1:0] r_nextIdx, w_nextIdxNext;
   logic [CNT_W-1:0] r_tickIdx, w_tickIdxNext;
   logic             r_tick, w_tickNext;
   logic             r_done, w_doneNext;

   logic             w_hs;
   logic             w_finish;
   logic             w_load;
   logic [WIDTH-1:0] w_loadPeriod;
   logic [CNT_W-1:0] w_loadCount;

`ifdef TICK_SEQ_PENDING_EN
   logic             r_shValid, w_shValidNext;
   logic [WIDTH-1:0] r_shPeriod, w_shPeriodNext;
   logic [CNT_W-1:0] r_shCount, w_shCountNext;

   // While running, the shadow slot is the only place a new config can go.
   assign cfg.cfg_ready = !rst && ((r_state == IDLE) || !r_shValid);
`else
   assign cfg.cfg_ready = !rst && (r_state == IDLE);
`endif

   assign w_hs = cfg.cfg_valid && cfg.cfg_ready;

   // A burst is over when its last tick is on the output, or immediately when
   // an empty burst was chained in from the shadow register.
   assign w_finish = (r_count == '0) ||
                     (r_tick && (r_tickIdx == r_count - CNT_W'(1)));

   assign o_tick     = r_tick;
   assign o_tick_idx = r_tickIdx;
   assign o_busy     = (r_state == RUN);
   assign o_done     = r_done;

   // Next-state logic. The cycle in which a burst starts counts as counter
   // value 0, so after the load the counter holds 1 (or wraps straight back to
   // 0 with a tick when the period is 0). That places tick k in cycle k*(P+1).
   always_comb begin
      w_stateNext   = r_state;
      w_cntNext     = r_cnt;
      w_periodNext  = r_period;
      w_countNext   = r_count;
      w_nextIdxNext = r_nextIdx;
      w_tickIdxNext = r_tickIdx;
      w_tickNext    = 1'b0;
      w_doneNext    = 1'b0;
      w_load        = 1'b0;
      w_loadPeriod  = cfg.cfg_period;
      w_loadCount   = cfg.cfg_count;
`ifdef TICK_SEQ_PENDING_EN
      w_shValidNext  = r_shValid;
      w_shPeriodNext = r_shPeriod;
      w_shCountNext  = r_shCount;
`endif

      case (r_state)
         IDLE: begin
            if (w_hs) begin
               if (cfg.cfg_count == '0) begin
                  w_doneNext = 1'b1;
               end else begin
                  w_load = 1'b1;
               end
            end
         end
         RUN: begin
            if (i_abort) begin
               w_stateNext = IDLE;
`ifdef TICK_SEQ_PENDING_EN
               w_shValidNext = 1'b0;
`endif
            end else if (w_finish) begin
               w_doneNext  = 1'b1;
               w_stateNext = IDLE;
`ifdef TICK_SEQ_PENDING_EN
               if (r_shValid) begin
                  w_load        = 1'b1;
                  w_loadPeriod  = r_shPeriod;
                  w_loadCount   = r_shCount;
                  w_shValidNext = 1'b0;
               end else if (w_hs) begin
                  w_load = 1'b1;
               end
`endif
            end else begin
               if (r_cnt == r_period) begin
                  w_cntNext     = '0;
                  w_tickNext    = 1'b1;
                  w_tickIdxNext = r_nextIdx;
                  w_nextIdxNext = r_nextIdx + CNT_W'(1);
               end else begin
                  w_cntNext = r_cnt + WIDTH'(1);
               end
`ifdef TICK_SEQ_PENDING_EN
               if (w_hs) begin
                  w_shValidNext  = 1'b1;
                  w_shPeriodNext = cfg.cfg_period;
                  w_shCountNext  = cfg.cfg_count;
               end
`endif
            end
         end
         default: w_stateNext = IDLE;
      endcase

      // Starting a burst, either from IDLE or chained after a finished one.
      if (w_load) begin
         w_stateNext   = RUN;
         w_periodNext  = w_loadPeriod;
         w_countNext   = w_loadCount;
         w_nextIdxNext = '0;
         if (w_loadPeriod == '0) begin
            w_cntNext = '0;
            if (w_loadCount != '0) begin
               w_tickNext    = 1'b1;
               w_tickIdxNext = '0;
               w_nextIdxNext = CNT_W'(1);
            end
         end else begin
            w_cntNext = WIDTH'(1);
         end
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_period  <= '0;
         r_count   <= '0;
         r_nextIdx <= '0;
         r_tickIdx <= '0;
         r_tick    <= 1'b0;
         r_done    <= 1'b0;
`ifdef TICK_SEQ_PENDING_EN
         r_shValid  <= 1'b0;
         r_shPeriod <= '0;
         r_shCount  <= '0;
`endif
      end else begin
         r_state   <= w_stateNext;
         r_cnt     <= w_cntNext;
         r_period  <= w_periodNext;
         r_count   <= w_countNext;
         r_nextIdx <= w_nextIdxNext;
         r_tickIdx <= w_tickIdxNext;
         r_tick    <= w_tickNext;
         r_done    <= w_doneNext;
`ifdef TICK_SEQ_PENDING_EN
         r_shValid  <= w_shValidNext;
         r_shPeriod <= w_shPeriodNext;
         r_shCount  <= w_shCountNext;
`endif
      end
   end

endmodule

// File: tb/tb_tick_burst_sequencer.sv
// ---------------------------------------------------------------------------
// tb_tick_burst_sequencer
// Directed bench for tick_burst_sequencer. Every accepted configuration pushes
// its expected tick cycles/indices and done cycle into scoreboard queues; a
// monitor on the falling edge pops and compares whenever the DUT strobes.
// ---------------------------------------------------------------------------
module tb_tick_burst_sequencer;
   localparam int WIDTH = 8;
   localparam int CNT_W = 16;
`ifdef TICK_SEQ_PENDING_EN
   localparam bit PENDING = 1'b1;
`else
   localparam bit PENDING = 1'b0;
`endif

   typedef struct {
      int cyc;
      int idx;
   } tickExp_t;

   logic             clk;
   logic             rst;
   logic             abort;
   logic             tick;
   logic [CNT_W-1:0] tickIdx;
   logic             busy;
   logic             done;

   tickExp_t tickQ[$];
   int       doneQ[$];
   tickExp_t monE;
   int       monD;
   int       cyc = 0;
   int       testsRun = 0;
   int       testsFailed = 0;
   int       burstEnd = 0;
   int       c0;

   tick_burst_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) cfgIf ();

   tick_burst_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg        (cfgIf),
      .i_abort    (abort),
      .o_tick     (tick),
      .o_tick_idx (tickIdx),
      .o_busy     (busy),
      .o_done     (done)
   );

   // Free-running clock and cycle counter used as the bench's time base.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic waitUntil(input int c);
      while (cyc < c) step();
   endtask

   // Expected ticks land in cycles start + k*(P+1); done follows the last one.
   task automatic pushBurst(input int start, input int p, input int n);
      tickExp_t e;
      for (int k = 1; k <= n; k++) begin
         e.cyc = start + k * (p + 1);
         e.idx = k - 1;
         tickQ.push_back(e);
      end
      burstEnd = start + n * (p + 1);
      doneQ.push_back(burstEnd + 1);
   endtask

   // Drop expectations that an abort or reset in cycle c cancels.
   task automatic flushAfter(input int c);
      tickExp_t keepT[$];
      int       keepD[$];
      foreach (tickQ[i]) if (tickQ[i].cyc <= c) keepT.push_back(tickQ[i]);
      foreach (doneQ[i]) if (doneQ[i] <= c) keepD.push_back(doneQ[i]);
      tickQ = keepT;
      doneQ = keepD;
   endtask

   task automatic applyStimulus(input string tag, input int p, input int n,
                                input int start, input bit expReady,
                                input bit doPush);
      checkOutput(tag, 32'(cfgIf.cfg_ready), 32'(expReady));
      cfgIf.cfg_valid  = 1'b1;
      cfgIf.cfg_period = WIDTH'(p);
      cfgIf.cfg_count  = CNT_W'(n);
      if (doPush) pushBurst(start, p, n);
      step();
      cfgIf.cfg_valid  = 1'b0;
      cfgIf.cfg_period = '0;
      cfgIf.cfg_count  = '0;
   endtask

   // Scoreboard monitor: every strobe must match the head of its queue.
   always @(negedge clk) begin
      if (tick === 1'b1) begin
         if (tickQ.size() == 0) begin
            checkOutput("spurious_tick_cycle", cyc, 32'hFFFF_FFFF);
         end else begin
            monE = tickQ.pop_front();
            checkOutput("tick_cycle", cyc, monE.cyc);
            checkOutput("tick_idx", 32'(tickIdx), monE.idx);
         end
      end
      if (done === 1'b1) begin
         if (doneQ.size() == 0) begin
            checkOutput("spurious_done_cycle", cyc, 32'hFFFF_FFFF);
         end else begin
            monD = doneQ.pop_front();
            checkOutput("done_cycle", cyc, monD);
         end
      end
   end

   initial begin
      rst              = 1'b1;
      abort            = 1'b0;
      cfgIf.cfg_valid  = 1'b0;
      cfgIf.cfg_period = '0;
      cfgIf.cfg_count  = '0;
      step();
      step();
      step();
      checkOutput("rst_tick", 32'(tick), 0);
      checkOutput("rst_busy", 32'(busy), 0);
      checkOutput("rst_done", 32'(done), 0);
      checkOutput("rst_tick_idx", 32'(tickIdx), 0);
      checkOutput("rst_ready", 32'(cfgIf.cfg_ready), 0);
      rst = 1'b0;
      #1;
      checkOutput("ready_after_rst", 32'(cfgIf.cfg_ready), 1);

      // P=3, N=4: ticks 4,8,12,16, done 17, busy 1..16.
      c0 = cyc;
      applyStimulus("A_ready", 3, 4, c0, 1'b1, 1'b1);
      checkOutput("A_busy_c1", 32'(busy), 1);
      waitUntil(c0 + 16);
      checkOutput("A_busy_c16", 32'(busy), 1);
      checkOutput("A_ready_run", 32'(cfgIf.cfg_ready), PENDING ? 1 : 0);
      step();
      checkOutput("A_busy_c17", 32'(busy), 0);
      checkOutput("A_ready_c17", 32'(cfgIf.cfg_ready), 1);

      // P=0, N=3: back-to-back ticks 1,2,3, done 4.
      c0 = cyc;
      applyStimulus("B_ready", 0, 3, c0, 1'b1, 1'b1);
      waitUntil(c0 + 4);
      checkOutput("B_busy_c4", 32'(busy), 0);
      step();

      // Empty burst: done in cycle 1, never busy.
      c0 = cyc;
      applyStimulus("C_ready", 5, 0, c0, 1'b1, 1'b1);
      checkOutput("C_busy_c1", 32'(busy), 0);
      step();

      // P=2, N=10 aborted in cycle 7: ticks 3,6 only, new config in cycle 8.
      c0 = cyc;
      applyStimulus("D_ready", 2, 10, c0, 1'b1, 1'b1);
      waitUntil(c0 + 7);
      abort = 1'b1;
      flushAfter(c0 + 7);
      step();
      abort = 1'b0;
      checkOutput("D_busy_c8", 32'(busy), 0);
      applyStimulus("D_ready_c8", 1, 2, cyc, 1'b1, 1'b1);
      waitUntil(c0 + 14);

      // abort together with cfg_valid in IDLE: config still accepted.
      c0 = cyc;
      abort = 1'b1;
      applyStimulus("E_ready", 1, 1, c0, 1'b1, 1'b1);
      abort = 1'b0;
      checkOutput("E_busy_c1", 32'(busy), 1);
      waitUntil(c0 + 4);
      checkOutput("E_busy_c4", 32'(busy), 0);

      // P=1, N=8 with reset in cycle 5; a config offered mid-burst has no effect.
      c0 = cyc;
      applyStimulus("F_ready", 1, 8, c0, 1'b1, 1'b1);
      waitUntil(c0 + 2);
      applyStimulus("F_ready_run", 4, 3, cyc, PENDING, 1'b0);
      waitUntil(c0 + 5);
      rst = 1'b1;
      flushAfter(c0 + 5);
      step();
      checkOutput("F_tick_c6", 32'(tick), 0);
      checkOutput("F_busy_c6", 32'(busy), 0);
      checkOutput("F_done_c6", 32'(done), 0);
      checkOutput("F_ready_in_rst", 32'(cfgIf.cfg_ready), 0);
      rst = 1'b0;
      #1;
      checkOutput("F_ready_after_rst", 32'(cfgIf.cfg_ready), 1);
      waitUntil(c0 + 20);
      checkOutput("F_busy_c20", 32'(busy), 0);

      // Full-range period: 256-cycle spacing, two ticks.
      c0 = cyc;
      applyStimulus("G_ready", 255, 2, c0, 1'b1, 1'b1);
      waitUntil(c0 + 300);
      checkOutput("G_busy_mid", 32'(busy), 1);
      waitUntil(c0 + 515);
      checkOutput("G_busy_end", 32'(busy), 0);

`ifdef TICK_SEQ_PENDING_EN
      // Chained burst: ticks 2,4,7,10, done 5 and 11, busy 1..10.
      c0 = cyc;
      applyStimulus("H_ready", 1, 2, c0, 1'b1, 1'b1);
      applyStimulus("H_ready_shadow", 2, 2, burstEnd, 1'b1, 1'b1);
      waitUntil(c0 + 5);
      checkOutput("H_busy_c5", 32'(busy), 1);
      waitUntil(c0 + 10);
      checkOutput("H_busy_c10", 32'(busy), 1);
      step();
      checkOutput("H_busy_c11", 32'(busy), 0);
      waitUntil(c0 + 14);
`endif

      step();
      checkOutput("tick_queue_empty", tickQ.size(), 0);
      checkOutput("done_queue_empty", doneQ.size(), 0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
